// File: rtl/ysyx_22040632_ifu.sv
// Instruction fetch stage: one outstanding 64-bit imem read, 32-bit word select,
// and a single output slot to decode that absorbs stalls, port blocking and redirects.
module ysyx_22040632_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rrst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_id,
  input  logic        block_id2if,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [63:0] imem_rsp_data,
  output logic [31:0] pc2id,
  output logic [31:0] inst2id,
  output logic        valid2id
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        slot_vld_q, slot_vld_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_inst_q, slot_inst_d;

  logic        hs;
  logic [31:0] inst_sel;
  logic [31:0] pc_inc;

  // Request side depends only on state, pc and the blocking/reset inputs.
  assign imem_req_valid = (state_q == S_REQ) && !block_id2if && !rrst;
  assign imem_req_addr  = {pc_q[31:3], 3'b000};
  assign hs             = imem_req_valid && imem_req_ready;
  assign inst_sel       = pc_q[2] ? imem_rsp_data[63:32] : imem_rsp_data[31:0];
  assign pc_inc         = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    hold_inst_d = hold_inst_q;
    slot_vld_d  = stall_id ? slot_vld_q  : 1'b0;
    slot_pc_d   = stall_id ? slot_pc_q   : 32'd0;
    slot_inst_d = stall_id ? slot_inst_q : 32'd0;

    case (state_q)
      S_REQ: begin
        if (hs) state_d = S_WAIT;
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (hs) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (stall_id) begin
            hold_inst_d = inst_sel;
            state_d     = S_HOLD;
          end else begin
            slot_vld_d  = 1'b1;
            slot_pc_d   = pc_q;
            slot_inst_d = inst_sel;
            pc_d        = pc_inc;
            state_d     = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!stall_id) begin
          slot_vld_d  = 1'b1;
          slot_pc_d   = pc_q;
          slot_inst_d = hold_inst_q;
          pc_d        = pc_inc;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A redirect flushes the presented slot even under a decode stall.
    if (redirect_valid) begin
      slot_vld_d  = 1'b0;
      slot_pc_d   = 32'd0;
      slot_inst_d = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      hold_inst_q <= 32'd0;
      slot_vld_q  <= 1'b0;
      slot_pc_q   <= 32'd0;
      slot_inst_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      hold_inst_q <= hold_inst_d;
      slot_vld_q  <= slot_vld_d;
      slot_pc_q   <= slot_pc_d;
      slot_inst_q <= slot_inst_d;
    end
  end

  assign valid2id = slot_vld_q;
  assign pc2id    = slot_pc_q;
  assign inst2id  = slot_inst_q;

endmodule

// File: tb/tb_ysyx_22040632_ifu.sv
// Directed bench for the fetch stage; memory returns {~(addr+4), ~addr}, so the
// instruction expected for any pc is simply ~pc.
module tb_ysyx_22040632_ifu;

  logic        clk = 1'b0;
  logic        rrst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_id;
  logic        block_id2if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic [31:0] pc2id;
  logic [31:0] inst2id;
  logic        valid2id;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  ysyx_22040632_ifu dut (
    .clk            (clk),
    .rrst           (rrst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_id       (stall_id),
    .block_id2if    (block_id2if),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc2id          (pc2id),
    .inst2id        (inst2id),
    .valid2id       (valid2id)
  );

  always #5 clk = ~clk;

  // Memory model: response lat cycles after the accepting edge, dropped on reset.
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;
  always @(posedge clk or posedge rrst) begin
    if (rrst) begin
      pend           <= 1'b0;
      pend_addr      <= 32'd0;
      cnt            <= 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 64'd0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        if (lat <= 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= {~(imem_req_addr + 32'd4), ~imem_req_addr};
        end else begin
          pend      <= 1'b1;
          pend_addr <= imem_req_addr;
          cnt       <= lat - 1;
        end
      end else if (pend) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          pend           <= 1'b0;
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= {~(pend_addr + 32'd4), ~pend_addr};
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    chk({tag, ".vld"},  64'(valid2id), 64'(v));
    chk({tag, ".pc"},   64'(pc2id),    64'(p));
    chk({tag, ".inst"}, 64'(inst2id),  64'(i));
  endtask

  task automatic req(input string tag, input logic v, input logic [31:0] a);
    chk({tag, ".rv"}, 64'(imem_req_valid), 64'(v));
    if (v) chk({tag, ".ra"}, 64'(imem_req_addr), 64'(a));
  endtask

  initial begin
    rrst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    stall_id = 1'b0; block_id2if = 1'b0; imem_req_ready = 1'b1;
    #3;
    req("rst", 1'b0, 32'd0);
    slot("rst", 1'b0, 32'd0, 32'd0);
    nxt(); nxt();
    req("rst_held", 1'b0, 32'd0);
    rrst = 1'b0;
    #1;
    // c0: first request
    req("c0", 1'b1, 32'h8000_0000);
    nxt(); // c1 WAIT
    req("c1", 1'b0, 32'd0);
    slot("c1", 1'b0, 32'd0, 32'd0);
    nxt(); // c2
    slot("c2", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
    req("c2", 1'b1, 32'h8000_0000);
    nxt(); // c3 bubble
    slot("c3", 1'b0, 32'd0, 32'd0);
    nxt(); // c4
    slot("c4", 1'b1, 32'h8000_0004, 32'h7FFF_FFFB);
    req("c4", 1'b1, 32'h8000_0008);
    nxt(); // c5
    slot("c5", 1'b0, 32'd0, 32'd0);
    nxt(); // c6
    slot("c6", 1'b1, 32'h8000_0008, 32'h7FFF_FFF7);
    nxt(); nxt(); // c8
    slot("c8", 1'b1, 32'h8000_000C, 32'h7FFF_FFF3);
    req("c8", 1'b1, 32'h8000_0010);

    // Stall across the response for 0x8000_0010
    stall_id = 1'b1;
    nxt(); // c9 WAIT, slot held
    slot("st9", 1'b1, 32'h8000_000C, 32'h7FFF_FFF3);
    req("st9", 1'b0, 32'd0);
    nxt(); // c10 HOLD
    slot("st10", 1'b1, 32'h8000_000C, 32'h7FFF_FFF3);
    req("st10", 1'b0, 32'd0);
    chk("st10.state", 64'(dut.state_q), 64'd2);
    nxt(); // c11
    stall_id = 1'b0;
    #1;
    req("st11", 1'b0, 32'd0);
    slot("st11", 1'b1, 32'h8000_000C, 32'h7FFF_FFF3);
    nxt(); // c12
    slot("st12", 1'b1, 32'h8000_0010, 32'h7FFF_FFEF);
    req("st12", 1'b1, 32'h8000_0010);
    lat = 4;
    nxt(); // c13 WAIT for 0x8000_0014, slow response
    slot("st13", 1'b0, 32'd0, 32'd0);
    lat = 1;

    // Redirect while waiting; stale response arrives later and is dropped
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    nxt(); // c14
    redirect_valid = 1'b0;
    #1;
    req("rd14", 1'b0, 32'd0);
    slot("rd14", 1'b0, 32'd0, 32'd0);
    nxt(); // c15
    req("rd15", 1'b0, 32'd0);
    nxt(); // c16 stale response on the bus
    chk("rd16.rsp", 64'(imem_rsp_valid), 64'd1);
    req("rd16", 1'b0, 32'd0);
    nxt(); // c17
    req("rd17", 1'b1, 32'h8000_0100);
    slot("rd17", 1'b0, 32'd0, 32'd0);
    nxt(); nxt(); // c19
    slot("rd19", 1'b1, 32'h8000_0100, 32'h7FFF_FEFF);

    // Redirect in the same cycle as the response, with decode stalled
    stall_id = 1'b1;
    nxt(); // c20
    chk("rr20.rsp", 64'(imem_rsp_valid), 64'd1);
    slot("rr20", 1'b1, 32'h8000_0100, 32'h7FFF_FEFF);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    nxt(); // c21
    redirect_valid = 1'b0; stall_id = 1'b0;
    #1;
    slot("rr21", 1'b0, 32'd0, 32'd0);
    req("rr21", 1'b1, 32'h8000_0200);

    // Block for 5 cycles in REQ
    block_id2if = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      req($sformatf("blk%0d", i), 1'b0, 32'd0);
      if (i < 4) nxt();
    end
    nxt(); // c26
    block_id2if = 1'b0;
    #1;
    req("blk_end", 1'b1, 32'h8000_0200);
    nxt(); // c27 WAIT, block asserted
    block_id2if = 1'b1;
    nxt(); // c28
    slot("blkw", 1'b1, 32'h8000_0200, 32'h7FFF_FDFF);
    req("blkw", 1'b0, 32'd0);

    // Wrap: redirect to the top of the address space while blocked
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    nxt(); // c29
    redirect_valid = 1'b0; block_id2if = 1'b0;
    #1;
    req("wr29", 1'b1, 32'hFFFF_FFF8);
    nxt(); nxt(); // c31
    slot("wr31", 1'b1, 32'hFFFF_FFFC, 32'h0000_0003);
    req("wr31", 1'b1, 32'h0000_0000);
    nxt(); nxt(); // c33
    slot("wr33", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040632_ifu.md
# ysyx_22040632_ifu

Instruction fetch stage of the in-order RV64 pipeline, directly upstream of the decode stage. Keeps the fetch PC, issues one 64-bit instruction-memory read at a time over a valid/ready request channel, and selects the 32-bit word. Presents `{pc2id, inst2id}` to decode and absorbs decode stalls, LSU port blocking and EX redirects (branch, jump, mret, ecall, fence.i). Empty slots are sent to decode as `inst2id = 0`, which decode treats as `nop`.

## Interface
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `rrst` input 1: asynchronous, active-high reset.
- `redirect_valid` input 1: EX flush; the next fetch comes from `redirect_pc`.
- `redirect_pc` input 32: redirect target, 4-byte aligned.
- `stall_id` input 1: decode cannot accept; the output slot must hold.
- `block_id2if` input 1: LSU owns the memory port; no new request may be issued.
- `imem_req_valid` output 1: read request.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_req_addr` output 32: `{pc[31:3], 3'b000}`.
- `imem_rsp_valid` input 1: read data valid, one cycle per request.
- `imem_rsp_data` input 64: read data.
- `pc2id` output 32: PC of the presented instruction; 0 when the slot is empty.
- `inst2id` output 32: presented instruction; 0 when the slot is empty.
- `valid2id` output 1: slot holds a real instruction.

## Operation
- FSM states:
  - REQ: request outstanding.
  - WAIT: accepted, awaiting data.
  - HOLD: data captured while decode is stalled.
- Registers: `pc` (32), `kill` (1), `hold_inst` (32), output slot `{valid_q, pc_q, inst_q}`.
- Word select: `inst = pc[2] ? rsp_data[63:32] : rsp_data[31:0]`.
- REQ:
  - `imem_req_valid = !block_id2if`.
  - On handshake, go to WAIT.
- WAIT, `imem_rsp_valid` high:
  - If `kill` is set: discard the data, clear `kill`, go to REQ.
  - Else if `stall_id`: `hold_inst <= inst`, go to HOLD.
  - Else: slot loads `{1, pc, inst}`, `pc <= pc + 4`, go to REQ.
- HOLD:
  - When `stall_id` drops, slot loads `{1, pc, hold_inst}`, `pc <= pc + 4`, go to REQ.
- Output slot:
  - Holds its value while `stall_id` is high.
  - Otherwise it clears to `{0, 0, 0}` unless loaded the same cycle.
- Redirect has priority over stall and load. Action by state:
  - REQ, no handshake this cycle: `pc <= redirect_pc`, stay in REQ.
  - REQ, handshake this cycle: `pc <= redirect_pc`, `kill <= 1`, go to WAIT.
  - WAIT, response not arriving: `pc <= redirect_pc`, `kill <= 1`.
  - WAIT, response arriving: drop the data, `kill <= 0`, `pc <= redirect_pc`, go to REQ.
  - HOLD: drop `hold_inst`, `pc <= redirect_pc`, go to REQ.
  - Every state: the output slot clears at the same edge, even if `stall_id` is high.
- `pc + 4` wraps modulo 2^32.
- Only one request is outstanding at a time.
- `block_id2if` never cancels an already-accepted request.

## Timing
- Reset (asynchronous, effective while `rrst` is high):
  - state REQ, `pc = RESET_PC`, `kill = 0`.
  - `valid2id = 0`, `pc2id = 0`, `inst2id = 0`.
  - `imem_req_valid = 0` while reset is held.
- Request outputs are driven from state and `pc` only; no combinational path from `imem_rsp_*`.
- `imem_req_addr` and `imem_req_valid` stay stable in REQ until handshake, except when a redirect changes `pc`.
- Latency with zero-wait memory (ready=1, response one cycle after accept):
  - Request handshake in cycle n, response in n+1.
  - Slot visible in n+2; the next request issues in n+2.
  - Throughput is one instruction per 2 cycles.
- Redirect asserted in cycle n: the first request to `redirect_pc` is valid in cycle n+1, or in the cycle after the killed response returns.
- Reset mid-WAIT: any later stray response is ignored (state REQ, `kill = 0`).
  - The memory model must not return data for pre-reset requests.

## Test plan
- Reset release, zero-wait memory returning `{inst(pc+4), inst(pc)}`:
  - First request is at 0x8000_0000.
  - `inst2id` shows words 0x8000_0000, 0x8000_0004 and 0x8000_0008 in order.
  - A 0 slot appears between them.
  - `imem_req_addr` for pc 0x8000_0004 is 0x8000_0000.
- `stall_id` high for 3 cycles across the response for 0x8000_0010:
  - The earlier slot holds.
  - State enters HOLD, with no new request.
  - After the stall: 0x8000_0010 is presented exactly once, then a request for 0x8000_0014.
- Redirect to 0x8000_0100 while in WAIT, response 4 cycles later:
  - The response is discarded.
  - Next request is 0x8000_0100.
  - No slot ever shows the old PC.
- Redirect in the same cycle as `imem_rsp_valid`:
  - The data is dropped.
  - Request to the target is valid the next cycle.
  - `valid2id = 0` that edge, even with `stall_id = 1`.
- `block_id2if` high for 5 cycles in REQ:
  - `imem_req_valid = 0` throughout.
  - Request resumes with an unchanged address.
  - If asserted during WAIT, the response is still delivered.
- PC 0xFFFF_FFFC fetch: next pc wraps to 0x0000_0000; word selected from `[63:32]`.
